// File: rtl/card_dealer.sv
// Stimulus source: deals two 4-bit card streams from one 52-card deck using a
// seeded 16-bit LFSR, with hold backpressure and a periodic deck refill.
module card_dealer #(
  parameter int unsigned CARDS_PER_HAND  = 5,
  parameter int unsigned EPOCHS_PER_DECK = 5,
  parameter int unsigned GAP_CYCLES      = 2,
  parameter logic [15:0] RESET_SEED      = 16'hACE1
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        start,
  input  logic        seed_valid,
  input  logic [15:0] seed,
  input  logic        hold,
  output logic        in_valid1,
  output logic [3:0]  user1,
  output logic        in_valid2,
  output logic [3:0]  user2,
  output logic        busy,
  output logic        round_done,
  output logic [5:0]  deck_left
);

  localparam int unsigned HW = $clog2(CARDS_PER_HAND + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
  localparam int unsigned EW = $clog2(EPOCHS_PER_DECK + 1);

  localparam logic [HW-1:0] HandLast  = HW'(CARDS_PER_HAND - 1);
  localparam logic [GW-1:0] GapLast   = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [EW-1:0] EpochLast = EW'(EPOCHS_PER_DECK - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StDeal1 = 3'd1;
  localparam logic [2:0] StGap   = 3'd2;
  localparam logic [2:0] StDeal2 = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [HW-1:0] hand_q, hand_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [EW-1:0] epoch_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [2:0]    count_q [13];

  logic [3:0] cand;
  logic [3:0] pick_idx;
  logic [4:0] idx;
  logic       found;
  logic [3:0] card_val;
  logic       deal;

  // Remaining copies of each value live at index value-1.
  always_comb begin
    cand     = (lfsr_q[3:0] >= 4'd13) ? lfsr_q[3:0] - 4'd13 : lfsr_q[3:0];
    pick_idx = cand;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < 13; i++) begin
      idx = {1'b0, cand} + 5'(i);
      if (idx >= 5'd13) idx = idx - 5'd13;
      if (!found && count_q[idx[3:0]] != 3'd0) begin
        pick_idx = idx[3:0];
        found    = 1'b1;
      end
    end
    card_val = pick_idx + 4'd1;
  end

  assign deal = ((state_q == StDeal1) || (state_q == StDeal2)) && !hold;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    if (state_q == StIdle && seed_valid) begin
      lfsr_d = (seed == 16'd0) ? RESET_SEED : seed;
    end
  end

  always_comb begin
    state_d = state_q;
    hand_d  = hand_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDeal1;
          hand_d  = '0;
        end
      end
      StDeal1: begin
        if (!hold) begin
          if (hand_q == HandLast) begin
            hand_d  = '0;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? StDeal2 : StGap;
          end else begin
            hand_d = hand_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (!hold) begin
          if (gap_q == GapLast) state_d = StDeal2;
          else                  gap_d   = gap_q + 1'b1;
        end
      end
      StDeal2: begin
        if (!hold) begin
          if (hand_q == HandLast) state_d = StDone;
          else                    hand_d  = hand_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= StIdle;
      hand_q     <= '0;
      gap_q      <= '0;
      epoch_q    <= '0;
      lfsr_q     <= RESET_SEED;
      for (int v = 0; v < 13; v++) count_q[v] <= 3'd4;
      deck_left  <= 6'd52;
      in_valid1  <= 1'b0;
      user1      <= 4'd0;
      in_valid2  <= 1'b0;
      user2      <= 4'd0;
      busy       <= 1'b0;
      round_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      hand_q     <= hand_d;
      gap_q      <= gap_d;
      lfsr_q     <= lfsr_d;
      in_valid1  <= 1'b0;
      user1      <= 4'd0;
      in_valid2  <= 1'b0;
      user2      <= 4'd0;
      round_done <= 1'b0;
      if (state_q == StIdle && start) busy <= 1'b1;
      if (deal) begin
        count_q[pick_idx] <= count_q[pick_idx] - 3'd1;
        deck_left         <= deck_left - 6'd1;
        if (state_q == StDeal1) begin
          in_valid1 <= 1'b1;
          user1     <= card_val;
        end else begin
          in_valid2 <= 1'b1;
          user2     <= card_val;
        end
      end
      if (state_q == StDone) begin
        round_done <= 1'b1;
        busy       <= 1'b0;
        // Refill lands on the same cycle as round_done.
        if (epoch_q == EpochLast) begin
          epoch_q   <= '0;
          deck_left <= 6'd52;
          for (int v = 0; v < 13; v++) count_q[v] <= 3'd4;
        end else begin
          epoch_q <= epoch_q + 1'b1;
        end
      end
    end
  end

endmodule
